// File: rtl/ref_iq_buffer.sv
// Writable complex reference store with a ready/valid read port and a 3-entry output FIFO.
// Optional out-of-range flag beats: define REF_IQ_BUFFER_OOR_FLAG_EN.
module ref_iq_buffer #(
    parameter int buffer_length = 10,
    parameter int index_bits    = 4,
    parameter int i_bits        = 12,
    parameter int q_bits        = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     m_axis_load_tvalid,
    input  logic [index_bits-1:0]    m_axis_load_addr,
    input  logic [i_bits+q_bits-1:0] m_axis_load_tdata,
    input  logic                     m_axis_index_tvalid,
    input  logic [index_bits-1:0]    m_axis_index_tdata,
    output logic                     s_axis_index_tready,
    input  logic                     m_axis_tready,
    output logic                     s_axis_data_tvalid,
    output logic signed [i_bits-1:0] i,
    output logic signed [q_bits-1:0] q,
    output logic                     s_axis_data_tuser
);

    localparam int W = i_bits + q_bits;
    localparam logic [index_bits:0] LEN = (index_bits + 1)'(buffer_length);

    typedef struct packed {
        logic         oor;
        logic [W-1:0] word;
    } entry_t;

    logic [W-1:0] mem [buffer_length];
    entry_t       s1_r;
    logic         s1_valid_r;
    logic         s1_valid_s;
    entry_t       fifo_r [3];
    entry_t       fifo_s [3];
    logic [1:0]   count_r;
    logic [1:0]   count_s;
    logic [1:0]   wr_idx_s;
    logic         tready_r;
    logic         tready_s;
    logic         accept_s;
    logic         pop_s;
    logic         req_in_range_s;
    logic         load_in_range_s;

    assign accept_s        = m_axis_index_tvalid & tready_r;
    assign pop_s           = (count_r != 2'd0) & m_axis_tready;
    assign req_in_range_s  = ({1'b0, m_axis_index_tdata} < LEN);
    assign load_in_range_s = ({1'b0, m_axis_load_addr} < LEN);

    // Sample storage: written by the load port, never reset.
    always_ff @(posedge clk) begin
        if (m_axis_load_tvalid && load_in_range_s) begin
            mem[m_axis_load_addr] <= m_axis_load_tdata;
        end
    end

    // Stage-1 occupancy; out-of-range requests only occupy it when they produce a beat.
    always_comb begin
        s1_valid_s = 1'b0;
        if (accept_s) begin
`ifdef REF_IQ_BUFFER_OOR_FLAG_EN
            s1_valid_s = 1'b1;
`else
            s1_valid_s = req_in_range_s;
`endif
        end else begin
            s1_valid_s = 1'b0;
        end
    end

    // Stage 1 captures the word at the handshake edge, so a same-edge load is not yet visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_r       <= '0;
        end else begin
            s1_valid_r <= s1_valid_s;
            if (accept_s) begin
                s1_r.word <= req_in_range_s ? mem[m_axis_index_tdata] : {W{1'b0}};
`ifdef REF_IQ_BUFFER_OOR_FLAG_EN
                s1_r.oor  <= ~req_in_range_s;
`else
                s1_r.oor  <= 1'b0;
`endif
            end else begin
                s1_r <= s1_r;
            end
        end
    end

    // Shift FIFO with the head in slot 0; a pop of the last entry leaves slot 0 as the held output.
    always_comb begin
        fifo_s = fifo_r;
        if (pop_s && (count_r >= 2'd2)) begin
            fifo_s[0] = fifo_r[1];
            fifo_s[1] = fifo_r[2];
        end else begin
            fifo_s[0] = fifo_r[0];
        end
        wr_idx_s = count_r - {1'b0, pop_s};
        if (s1_valid_r) begin
            fifo_s[wr_idx_s] = s1_r;
        end else begin
            fifo_s[0] = fifo_s[0];
        end
        count_s  = count_r - {1'b0, pop_s} + {1'b0, s1_valid_r};
        tready_s = (({1'b0, count_s} + {2'b00, s1_valid_s}) < 3'd3);
    end

    // FIFO storage, occupancy and the registered request-ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_r[0] <= '0;
            fifo_r[1] <= '0;
            fifo_r[2] <= '0;
            count_r   <= 2'd0;
            tready_r  <= 1'b0;
        end else begin
            fifo_r    <= fifo_s;
            count_r   <= count_s;
            tready_r  <= tready_s;
        end
    end

    assign s_axis_index_tready = tready_r;
    assign s_axis_data_tvalid  = (count_r != 2'd0);
    assign i                   = $signed(fifo_r[0].word[W-1:q_bits]);
    assign q                   = $signed(fifo_r[0].word[q_bits-1:0]);
    assign s_axis_data_tuser   = fifo_r[0].oor;

endmodule

// File: tb/tb_ref_iq_buffer.sv
// Randomized self-checking bench for ref_iq_buffer against a beat-queue reference model.
module tb_ref_iq_buffer;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               lv = 1'b0;
    logic [3:0]         laddr = 4'd0;
    logic [23:0]        ldata = 24'd0;
    logic               rv = 1'b0;
    logic [3:0]         ridx = 4'd0;
    logic               idx_ready;
    logic               mt = 1'b0;
    logic               dv;
    logic signed [11:0] i_o;
    logic signed [11:0] q_o;
    logic               tu;

    always #5 clk = ~clk;

    ref_iq_buffer #(
        .buffer_length(10), .index_bits(4), .i_bits(12), .q_bits(12)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_axis_load_tvalid(lv), .m_axis_load_addr(laddr), .m_axis_load_tdata(ldata),
        .m_axis_index_tvalid(rv), .m_axis_index_tdata(ridx),
        .s_axis_index_tready(idx_ready), .m_axis_tready(mt),
        .s_axis_data_tvalid(dv), .i(i_o), .q(q_o), .s_axis_data_tuser(tu)
    );

    typedef struct {
        logic [23:0] word;
        logic        oor;
        int          avail;
    } beat_t;

    beat_t       exp_q[$];
    logic [23:0] ref_mem [10];
    logic [23:0] last_word = 24'd0;
    logic        last_oor = 1'b0;
    int          edge_n = 0;
    int          checks_cnt = 0;
    int          errors_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Called at a negedge: check outputs, drive inputs, predict the next edge, advance.
    task automatic step(input logic l_v, input logic [3:0] l_a, input logic [23:0] l_d,
                        input logic r_v, input logic [3:0] r_i, input logic m_t, output bit acc);
        bit    exp_valid;
        bit    exp_ready;
        beat_t b;
        exp_ready = (exp_q.size() < 3);
        exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= edge_n);
        check_val("idx_tready", {31'd0, idx_ready}, {31'd0, exp_ready});
        check_val("data_tvalid", {31'd0, dv}, {31'd0, exp_valid});
        if (exp_valid) begin
            check_val("data_iq", {8'd0, i_o, q_o}, {8'd0, exp_q[0].word});
            check_val("data_tuser", {31'd0, tu}, {31'd0, exp_q[0].oor});
        end else begin
            check_val("hold_iq", {8'd0, i_o, q_o}, {8'd0, last_word});
            check_val("hold_tuser", {31'd0, tu}, {31'd0, last_oor});
        end
        lv = l_v; laddr = l_a; ldata = l_d; rv = r_v; ridx = r_i; mt = m_t;
        if (exp_valid && m_t) begin
            last_word = exp_q[0].word;
            last_oor  = exp_q[0].oor;
            void'(exp_q.pop_front());
        end
        acc = r_v && exp_ready;
        if (acc) begin
            if (r_i < 4'd10) begin
                b.word = ref_mem[r_i]; b.oor = 1'b0; b.avail = edge_n + 2;
                exp_q.push_back(b);
            end else begin
`ifdef REF_IQ_BUFFER_OOR_FLAG_EN
                b.word = 24'd0; b.oor = 1'b1; b.avail = edge_n + 2;
                exp_q.push_back(b);
`endif
            end
        end
        if (l_v && (l_a < 4'd10)) ref_mem[l_a] = l_d;
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) step(1'b0, 4'd0, 24'd0, 1'b0, 4'd0, 1'b1, acc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_tvalid"}, {31'd0, dv}, 32'd0);
        check_val({tag, "_iq"}, {8'd0, i_o, q_o}, 32'd0);
        check_val({tag, "_tuser"}, {31'd0, tu}, 32'd0);
        check_val({tag, "_tready"}, {31'd0, idx_ready}, 32'd0);
    endtask

    initial begin
        bit acc;
        int n;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check_val("tready_before_edge", {31'd0, idx_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);

        // Preload {n, -n} and read it back-to-back at full rate.
        for (int k = 0; k < 10; k++) step(1'b1, 4'(k), {12'(k), 12'(-k)}, 1'b0, 4'd0, 1'b1, acc);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 4'd0, 24'd0, 1'b1, 4'(k), 1'b1, acc);
            check_val("b2b_accept", {31'd0, acc}, 32'd1);
        end
        idle(4);

        // Back-pressure: requests 0..3 with the sink stalled, then release.
        n = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 4'd0, 24'd0, (n < 4), 4'(n), 1'b0, acc);
            if (acc) n++;
        end
        check_val("stall_accepted", n, 3);
        for (int k = 0; k < 10 && n < 4; k++) begin
            step(1'b0, 4'd0, 24'd0, 1'b1, 4'(n), 1'b1, acc);
            if (acc) n++;
        end
        idle(5);

        // Extreme signed values at address 3.
        step(1'b1, 4'd3, {12'h7FF, 12'h800}, 1'b0, 4'd0, 1'b1, acc);
        step(1'b0, 4'd0, 24'd0, 1'b1, 4'd3, 1'b1, acc);
        step(1'b0, 4'd0, 24'd0, 1'b0, 4'd0, 1'b0, acc);
        check_val("signed_i", $signed(i_o), 2047);
        check_val("signed_q", $signed(q_o), -2048);
        idle(2);

        // Out-of-range request followed by a normal one.
        step(1'b0, 4'd0, 24'd0, 1'b1, 4'd12, 1'b1, acc);
        step(1'b0, 4'd0, 24'd0, 1'b1, 4'd4, 1'b1, acc);
        idle(4);

        // Same-edge load and read of address 5: old value first, new value next.
        step(1'b1, 4'd5, 24'hABC123, 1'b1, 4'd5, 1'b1, acc);
        step(1'b0, 4'd0, 24'd0, 1'b1, 4'd5, 1'b1, acc);
        idle(4);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 24'($urandom),
                 ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0), acc);
        end

        // Reset with beats queued.
        step(1'b0, 4'd0, 24'd0, 1'b1, 4'd0, 1'b0, acc);
        step(1'b0, 4'd0, 24'd0, 1'b1, 4'd1, 1'b0, acc);
        step(1'b0, 4'd0, 24'd0, 1'b0, 4'd0, 1'b0, acc);
        rv = 1'b0; lv = 1'b0;
        rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        exp_q.delete();
        last_word = 24'd0;
        last_oor  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_val("tready_after_release", {31'd0, idx_ready}, 32'd0);
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        for (int k = 0; k < 100; k++) begin
            step(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 24'($urandom),
                 ($urandom_range(0, 1) != 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) != 0), acc);
        end
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
